fir_ctrl: RTL
=============

FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 SHALL have parameter NTAP, default 11: number of FIR taps, one shared MAC.
REQ-002 SHALL have parameter AW, default 4: tap and data RAM address width, with 2^AW >= NTAP.
REQ-003 SHALL have one clock and a synchronous, active-high reset: wb_clk_i (in, 1) is the clock; wb_rst_i (in, 1) is the synchronous active-high reset.
REQ-004 SHALL have these control ports:
- ap_start_i (in, 1): start pulse.
- data_len_i (in, 32): samples per run, sampled on accepted start.
- ap_idle_o (out, 1): high in IDLE.
- ap_done_o (out, 1): one-cycle completion pulse.
REQ-005 SHALL have these stream ports:
- ss_tvalid_i, ss_tlast_i (in, 1): input stream valid and last.
- ss_tready_o (out, 1): input stream ready.
- sm_tvalid_o, sm_tlast_o (out, 1): output stream valid and last.
- sm_tready_i (in, 1): output stream ready.
REQ-006 SHALL have these datapath control ports:
- tap_addr_o (out, AW): tap RAM read address.
- data_addr_o (out, AW): data RAM address.
- data_we_o (out, 1): data RAM write enable.
- data_wsel_o (out, 1): write data select; 0 = zero, 1 = stream sample.
- mac_en_o (out, 1): MAC enable.
- mac_clr_o (out, 1): MAC loads the product instead of accumulating.
- tlast_err_o (out, 1): sticky framing error.

Function
REQ-007 SHALL implement the states IDLE, CLR, IN, CALC, DRAIN, OUT and DONE.
REQ-008 In IDLE, ap_start_i=1 SHALL latch data_len_i, clear the sample counter, head pointer and tlast_err_o, and go to CLR.
REQ-009 ap_start_i SHALL be ignored in every state except IDLE.
REQ-010 CLR SHALL last exactly NTAP cycles; each cycle drives data_we_o=1, data_wsel_o=0 and data_addr_o=0..NTAP-1. It then goes to IN, or to DONE if the latched length is 0.
REQ-011 In IN, ss_tready_o SHALL be 1.
REQ-012 On an IN handshake, the block SHALL write the sample (data_we_o=1, data_wsel_o=1, data_addr_o=head) and go to CALC; ss_tready_o SHALL be 0 in every other state.
REQ-013 CALC SHALL last NTAP cycles with k=0..NTAP-1, driving tap_addr_o=k and data_addr_o=(head-k) mod NTAP.
REQ-014 The RAM read latency SHALL be taken as 1: mac_en_o=1 on CALC k>=1 and on the single DRAIN cycle, and mac_clr_o=1 only on CALC k=1.
REQ-015 DRAIN SHALL go to OUT after one cycle.
REQ-016 OUT SHALL hold sm_tvalid_o=1 until sm_tready_i=1.
REQ-017 On the OUT handshake, the block SHALL advance head (NTAP-1 wraps to 0) and increment the sample counter.
REQ-018 After the OUT handshake, the block SHALL go to DONE if the counter equals the length, else to IN.
REQ-019 sm_tlast_o SHALL be 1 in OUT only for the final sample.
REQ-020 DONE SHALL assert ap_done_o for exactly one cycle, then go to IDLE.
REQ-021 Minimum per-sample latency SHALL be NTAP+3 cycles (14 at default), from IN handshake to OUT handshake inclusive.
REQ-022 tlast_err_o SHALL set on an accepted input beat whose ss_tlast_i differs from (counter == length-1). It stays set until the next accepted ap_start_i, and processing continues.
REQ-023 The sample counter and length SHALL be 32-bit unsigned, with no wrap within a run.

Reset
REQ-024 wb_rst_i=1 at any clock edge SHALL force IDLE with ap_idle_o=1.
REQ-025 Under reset, all other outputs SHALL be 0, and the counter, head and latched length SHALL be 0.
REQ-026 Reset mid-run SHALL abandon the run without issuing ap_done_o.

Structure
REQ-027 Package fir_pkg SHALL hold the state enum, NTAP/AW defaults and the 32-bit length type.
REQ-028 The circular head and tap index arithmetic SHALL be a sub-module fir_addr_gen; all other logic stays in fir_ctrl.

Verification
REQ-029 Reset then ap_start_i with len=3 and streams always ready -> 11 CLR writes, 3 outputs spaced 14 cycles apart, sm_tlast_o on the 3rd, ap_done_o pulse, ap_idle_o=1.
REQ-030 len=0 -> CLR (11 cycles), then ap_done_o, with no ss_tready_o or sm_tvalid_o ever asserted.
REQ-031 sm_tready_i low for 5 cycles in OUT -> sm_tvalid_o held, no address change, output accepted on the 6th cycle.
REQ-032 len=13 -> head wraps 10->0 after sample 11; on sample 12 with k=1, data_addr_o=10.
REQ-033 ss_tlast_i=1 on sample 2 of len=4 -> tlast_err_o=1 through to completion; all 4 outputs still produced; a new ap_start_i clears the flag.
REQ-034 wb_rst_i asserted during CALC, then len=1 -> no ap_done_o from the abandoned run; the new run behaves as if from a cold reset.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencer: FSM state encoding,
// default geometry and the sample-count type.
package fir_pkg;

    localparam int NTAP_DEF = 11;
    localparam int AW_DEF   = 4;

    // Sample counter / run length, unsigned, never wraps within a run
    typedef logic [31:0] len_t;

    // FSM encoding kept as plain constants so older tools can consume it
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLR   = 3'd1;
    localparam state_t ST_IN    = 3'd2;
    localparam state_t ST_CALC  = 3'd3;
    localparam state_t ST_DRAIN = 3'd4;
    localparam state_t ST_OUT   = 3'd5;
    localparam state_t ST_DONE  = 3'd6;

endpackage

// File: rtl/fir_addr_gen.sv
// Circular-buffer address arithmetic for the FIR sequencer.
// Purely combinational: the registers live in fir_ctrl.
module fir_addr_gen
    import fir_pkg::*;
#(
    parameter int NTAP = NTAP_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic [AW-1:0] head,       // newest sample slot
    input  logic [AW-1:0] k,          // tap index / clear index
    output logic [AW-1:0] head_next,  // head advanced with wrap at NTAP
    output logic [AW-1:0] data_addr,  // (head - k) mod NTAP
    output logic          k_last      // k reached NTAP-1
);

    localparam logic [AW-1:0] NTAP_A = AW'(NTAP);
    localparam logic [AW-1:0] TOP_A  = AW'(NTAP - 1);

    // The wrapped form head + NTAP - k is < NTAP <= 2^AW, so AW-bit
    // modular arithmetic yields the exact result even when NTAP == 2^AW.
    always_comb begin
        if (head >= k)
            data_addr = head - k;
        else
            data_addr = head + NTAP_A - k;
    end

    assign head_next = (head == TOP_A) ? '0 : head + AW'(1);
    assign k_last    = (k == TOP_A);

endmodule

// File: rtl/fir_ctrl.sv
// FIR control sequencer: clears the data RAM, then for each input sample
// writes it at the circular head, walks NTAP taps through one shared MAC,
// and presents one output beat. Datapath itself lives outside this block.
module fir_ctrl
    import fir_pkg::*;
#(
    parameter int NTAP = NTAP_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    // control
    input  logic          ap_start_i,
    input  logic [31:0]   data_len_i,
    output logic          ap_idle_o,
    output logic          ap_done_o,
    // input stream
    input  logic          ss_tvalid_i,
    input  logic          ss_tlast_i,
    output logic          ss_tready_o,
    // output stream
    output logic          sm_tvalid_o,
    output logic          sm_tlast_o,
    input  logic          sm_tready_i,
    // datapath control
    output logic [AW-1:0] tap_addr_o,
    output logic [AW-1:0] data_addr_o,
    output logic          data_we_o,
    output logic          data_wsel_o,
    output logic          mac_en_o,
    output logic          mac_clr_o,
    output logic          tlast_err_o
);

    state_t        state, state_nxt;
    logic [AW-1:0] idx;        // CLR address / CALC tap index
    logic [AW-1:0] head;       // slot of the newest sample
    logic [AW-1:0] head_nxt;
    logic [AW-1:0] calc_addr;
    logic          idx_last;
    len_t          len;
    len_t          cnt;        // outputs completed in this run
    logic          last_smp;
    logic          err;

    fir_addr_gen #(.NTAP(NTAP), .AW(AW)) u_addr (
        .head      (head),
        .k         (idx),
        .head_next (head_nxt),
        .data_addr (calc_addr),
        .k_last    (idx_last)
    );

    // Only evaluated in IN/OUT, where len >= 1 is guaranteed
    assign last_smp = (cnt == len - 32'd1);

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ap_start_i) state_nxt = ST_CLR;
            ST_CLR:   if (idx_last) state_nxt = (len == '0) ? ST_DONE : ST_IN;
            ST_IN:    if (ss_tvalid_i) state_nxt = ST_CALC;
            ST_CALC:  if (idx_last) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_OUT;
            ST_OUT:   if (sm_tready_i) state_nxt = last_smp ? ST_DONE : ST_IN;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, counters, head pointer and sticky framing error
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
            idx   <= '0;
            head  <= '0;
            cnt   <= '0;
            len   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (ap_start_i) begin
                        len  <= data_len_i;
                        cnt  <= '0;
                        head <= '0;
                        idx  <= '0;
                        err  <= 1'b0;
                    end
                end
                ST_CLR, ST_CALC: begin
                    idx <= idx_last ? '0 : idx + AW'(1);
                end
                ST_IN: begin
                    // Framing mismatch is recorded but never stalls the run
                    if (ss_tvalid_i && (ss_tlast_i != last_smp))
                        err <= 1'b1;
                end
                ST_OUT: begin
                    if (sm_tready_i) begin
                        head <= head_nxt;
                        cnt  <= cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore-style output decode; only the sample write follows ss_tvalid_i
    always_comb begin
        ap_idle_o   = (state == ST_IDLE);
        ap_done_o   = 1'b0;
        ss_tready_o = 1'b0;
        sm_tvalid_o = 1'b0;
        sm_tlast_o  = 1'b0;
        tap_addr_o  = '0;
        data_addr_o = '0;
        data_we_o   = 1'b0;
        data_wsel_o = 1'b0;
        mac_en_o    = 1'b0;
        mac_clr_o   = 1'b0;
        case (state)
            ST_CLR: begin
                data_we_o   = 1'b1;
                data_addr_o = idx;
            end
            ST_IN: begin
                ss_tready_o = 1'b1;
                data_addr_o = head;
                data_we_o   = ss_tvalid_i;
                data_wsel_o = ss_tvalid_i;
            end
            ST_CALC: begin
                tap_addr_o  = idx;
                data_addr_o = calc_addr;
                // RAM read data lags the address by one cycle: k=0 only
                // issues the read, k=1 loads the first product.
                mac_en_o    = (idx != '0);
                mac_clr_o   = (idx == AW'(1));
            end
            ST_DRAIN: mac_en_o = 1'b1;
            ST_OUT: begin
                sm_tvalid_o = 1'b1;
                sm_tlast_o  = last_smp;
            end
            ST_DONE: ap_done_o = 1'b1;
            default: ;
        endcase
    end

    assign tlast_err_o = err;

endmodule
